// File: rtl/riscv_pkg.sv
// Shared encodings for the instruction/data memory arbiter: response owner,
// last-grant record and requester bit positions.
package riscv_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_e;

  localparam int unsigned REQ_I = 0;
  localparam int unsigned REQ_D = 1;

  // One-hot grant vector to the requester that owns the coming response.
  function automatic owner_e owner_of(input logic [1:0] gnt);
    case (gnt)
      2'b01:   owner_of = OWN_I;
      2'b10:   owner_of = OWN_D;
      default: owner_of = OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant: a lone requester always wins, on contention the
// requester not recorded in last wins.
module mem_arb_rr
  import riscv_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Grant selection from the request pair and the last-grant record.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (last == LAST_I) begin
          gnt = 2'b10;
        end else begin
          gnt = 2'b01;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between an instruction-fetch port and
// a data port; fixed one-cycle response latency, one access per cycle.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_dout
);

  logic [1:0]        req_s;
  logic [1:0]        gnt_s;
  last_e             last_q;
  last_e             last_d;
  owner_e            owner_q;
  owner_e            owner_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  // Requests are masked while clear is low so no grant can leak out of reset.
  assign req_s = {d_req & clear, i_req & clear};

  mem_arb_rr u_rr (
    .req  (req_s),
    .last (last_q),
    .gnt  (gnt_s)
  );

  // Next-state: last grant, response owner and the held RAM address.
  always_comb begin
    last_d  = last_q;
    owner_d = owner_of(gnt_s);
    addr_d  = addr_q;
    if (gnt_s[REQ_I]) begin
      last_d = LAST_I;
      addr_d = i_addr;
    end else if (gnt_s[REQ_D]) begin
      last_d = LAST_D;
      addr_d = d_addr;
    end else begin
      last_d = last_q;
      addr_d = addr_q;
    end
  end

  // State registers; reset leaves I as last grant so D wins first contention.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      last_q  <= LAST_I;
      owner_q <= OWN_NONE;
      addr_q  <= {ADDR_W{1'b0}};
    end else begin
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
    end
  end

  assign i_gnt    = gnt_s[REQ_I];
  assign d_gnt    = gnt_s[REQ_D];
  assign ram_addr = addr_d;
  assign ram_din  = d_wdata;
  assign ram_wren = gnt_s[REQ_D] & d_we;

  assign i_valid  = (owner_q == OWN_I);
  assign d_valid  = (owner_q == OWN_D);
  assign i_rdata  = ram_dout;
  assign d_rdata  = ram_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural RAM plus a reference model
// of grants, responses and memory contents, driven by directed and random tasks.
module tb_mem_arbiter;

  logic        clock;
  logic        clear;
  logic        i_req;
  logic [7:0]  i_addr;
  logic        i_gnt;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic [7:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_wren;
  logic [31:0] ram_dout;
  logic        ram_init;

  int n_cmp;
  int n_bad;

  mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clock(clock), .clear(clear),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_wren(ram_wren), .ram_dout(ram_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a == 8'h05) return 32'h0000_0013;
    return {a, ~a, 8'h5A, a};
  endfunction

  // Environment RAM: single port, synchronous, read-before-write.
  logic [31:0] ram [256];
  always @(posedge clock) begin
    if (ram_init) begin
      for (int k = 0; k < 256; k++) ram[k] <= init_val(8'(k));
    end else begin
      if (ram_wren) ram[ram_addr] <= ram_din;
      ram_dout <= ram[ram_addr];
    end
  end

  // Reference model state.
  logic [31:0] m_mem [256];
  bit          m_last_d;
  int          m_exp_who;     // 0 none, 1 instruction, 2 data
  bit          m_exp_wr;
  logic [31:0] m_exp_data;

  // Result is {d, i}: lone requester wins, contention goes to the one not last served.
  function automatic logic [1:0] model_pick(input bit ir, input bit dr, input bit last_d);
    if (ir && dr) return last_d ? 2'b01 : 2'b10;
    return {dr, ir};
  endfunction

  task automatic model_commit(input logic [1:0] g);
    if (g[0]) begin
      m_exp_who = 1; m_exp_wr = 1'b0; m_exp_data = m_mem[i_addr]; m_last_d = 1'b0;
    end else if (g[1]) begin
      m_exp_who = 2; m_exp_wr = d_we; m_exp_data = m_mem[d_addr]; m_last_d = 1'b1;
      if (d_we) m_mem[d_addr] = d_wdata;
    end else begin
      m_exp_who = 0;
    end
  endtask

  task automatic model_reset();
    m_last_d = 1'b0; m_exp_who = 0; m_exp_wr = 1'b0;
  endtask

  task automatic drive(input bit ir, input logic [7:0] ia, input bit dr, input bit we,
                       input logic [7:0] da, input logic [31:0] wd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    clear = 1'b0; drive(0, 8'h00, 0, 0, 8'h00, 32'h0);
    @(posedge clock); #1;
    clear = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    clear = 1'b0; drive(1, 8'h33, 1, 1, 8'h44, 32'h1234_5678);
    @(negedge clock);
    n_cmp++;
    if ({i_gnt, d_gnt, i_valid, d_valid, ram_wren} !== 5'b00000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {i_gnt, d_gnt, i_valid, d_valid, ram_wren});
    end
    n_cmp++;
    if (ram_addr !== 8'h00) begin
      n_bad++; $display("FAIL reset_addr: got %h want 00", ram_addr);
    end
    @(posedge clock); #1;
    clear = 1'b1; drive(0, 8'h00, 0, 0, 8'h00, 32'h0);
    model_reset();
    @(negedge clock);
    n_cmp++;
    if ({i_valid, d_valid} !== 2'b00) begin
      n_bad++; $display("FAIL reset_release_valid: got %b want 00", {i_valid, d_valid});
    end
    model_commit(2'b00);
  endtask

  task automatic test_single_read();
    @(posedge clock); #1;
    drive(1, 8'h05, 0, 0, 8'h00, 32'h0);
    @(negedge clock);
    n_cmp++;
    if ({i_gnt, d_gnt, ram_wren, ram_addr} !== {3'b100, 8'h05}) begin
      n_bad++; $display("FAIL single_grant: got i=%b d=%b we=%b a=%h want 1 0 0 05", i_gnt, d_gnt, ram_wren, ram_addr);
    end
    model_commit(2'b01);
    @(posedge clock); #1;
    drive(0, 8'h05, 0, 0, 8'h00, 32'h0);
    @(negedge clock);
    n_cmp++;
    if ({i_valid, d_valid, i_rdata} !== {2'b10, 32'h0000_0013}) begin
      n_bad++; $display("FAIL single_data: got iv=%b dv=%b data=%h want 1 0 00000013", i_valid, d_valid, i_rdata);
    end
    model_commit(2'b00);
    @(posedge clock); #1;
    @(negedge clock);
    n_cmp++;
    if (i_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_once: i_valid got %b want 0", i_valid);
    end
    model_commit(2'b00);
  endtask

  task automatic test_contention();
    logic [1:0] want;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      if (k < 4) drive(1, 8'(8'h20 + k), 1, 0, 8'(8'h40 + k), 32'h0);
      else drive(0, 8'h00, 0, 0, 8'h00, 32'h0);
      @(negedge clock);
      want = (k >= 4) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
      n_cmp++;
      if ({d_gnt, i_gnt} !== want) begin
        n_bad++; $display("FAIL contention_gnt[%0d]: got d=%b i=%b want %b", k, d_gnt, i_gnt, want);
      end
      n_cmp++;
      if (k > 0 && ({d_valid, i_valid} !== ((k % 2 == 1) ? 2'b10 : 2'b01) || ram_dout !== m_exp_data)) begin
        n_bad++; $display("FAIL contention_rsp[%0d]: got dv=%b iv=%b data=%h want owner %0d data %h",
                          k, d_valid, i_valid, ram_dout, (k % 2 == 1) ? 2 : 1, m_exp_data);
      end
      model_commit(want);
    end
  endtask

  task automatic test_write_read();
    @(posedge clock); #1;
    drive(0, 8'h00, 1, 1, 8'h10, 32'hDEAD_BEEF);
    @(negedge clock);
    n_cmp++;
    if ({d_gnt, ram_wren, ram_addr, ram_din} !== {2'b11, 8'h10, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL write_cycle: got g=%b we=%b a=%h din=%h want 1 1 10 deadbeef", d_gnt, ram_wren, ram_addr, ram_din);
    end
    model_commit(2'b10);
    @(posedge clock); #1;
    drive(0, 8'h00, 1, 0, 8'h10, 32'h0);
    @(negedge clock);
    n_cmp++;
    if ({d_valid, d_gnt, ram_wren} !== 3'b110) begin
      n_bad++; $display("FAIL write_ack: got dv=%b g=%b we=%b want 1 1 0", d_valid, d_gnt, ram_wren);
    end
    model_commit(2'b10);
    @(posedge clock); #1;
    drive(0, 8'h00, 0, 0, 8'h00, 32'h0);
    @(negedge clock);
    n_cmp++;
    if ({d_valid, ram_wren, d_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL write_readback: got dv=%b we=%b data=%h want 1 0 deadbeef", d_valid, ram_wren, d_rdata);
    end
    model_commit(2'b00);
  endtask

  task automatic test_back_to_back();
    int grants = 0;
    int valids = 0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clock); #1;
      if (k < 8) drive(1, 8'(k), 0, 0, 8'h00, 32'h0);
      else drive(0, 8'h00, 0, 0, 8'h00, 32'h0);
      @(negedge clock);
      if (i_gnt) grants++;
      if (i_valid) begin
        valids++;
        n_cmp++;
        if (i_rdata !== init_val(8'(k - 1))) begin
          n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", k - 1, i_rdata, init_val(8'(k - 1)));
        end
      end
      model_commit((k < 8) ? 2'b01 : 2'b00);
    end
    n_cmp++;
    if (grants != 8 || valids != 8) begin
      n_bad++; $display("FAIL b2b_count: got %0d grants %0d valids want 8 8", grants, valids);
    end
  endtask

  task automatic test_reset_midaccess();
    @(posedge clock); #1;
    drive(0, 8'h00, 1, 0, 8'h22, 32'h0);
    @(negedge clock);
    n_cmp++;
    if (d_gnt !== 1'b1) begin
      n_bad++; $display("FAIL midreset_grant: d_gnt got %b want 1", d_gnt);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      clear = 1'b0; drive(1, 8'h07, 1, 1, 8'h23, 32'hFFFF_FFFF);
      @(negedge clock);
      n_cmp++;
      if ({i_gnt, d_gnt, i_valid, d_valid, ram_wren, ram_addr} !== 13'h0) begin
        n_bad++; $display("FAIL midreset_outputs[%0d]: got %b %h want 00000 00", k,
                          {i_gnt, d_gnt, i_valid, d_valid, ram_wren}, ram_addr);
      end
    end
    @(posedge clock); #1;
    clear = 1'b1; drive(0, 8'h00, 0, 0, 8'h00, 32'h0);
    model_reset();
    @(negedge clock);
    n_cmp++;
    if ({i_valid, d_valid} !== 2'b00) begin
      n_bad++; $display("FAIL midreset_no_valid: got %b want 00", {i_valid, d_valid});
    end
    model_commit(2'b00);
  endtask

  task automatic test_random();
    bit ip = 1'b0;
    bit dp = 1'b0;
    int iw = 0;
    int dw = 0;
    logic [1:0] eg;
    logic [1:0] ev;
    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #1;
      if (!ip && $urandom_range(0, 9) < 6) begin
        ip = 1'b1; iw = 0; i_addr = 8'($urandom_range(0, 15));
      end
      if (!dp && $urandom_range(0, 9) < 6) begin
        dp = 1'b1; dw = 0; d_addr = 8'($urandom_range(0, 15));
        d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end
      i_req = ip; d_req = dp;
      @(negedge clock);
      eg = model_pick(ip, dp, m_last_d);
      ev = {m_exp_who == 2, m_exp_who == 1};
      n_cmp++;
      if ({d_gnt, i_gnt} !== eg) begin
        n_bad++; $display("FAIL rnd_gnt[%0d]: got %b want %b", c, {d_gnt, i_gnt}, eg);
      end
      n_cmp++;
      if (ram_wren !== (eg[1] & d_we) || (eg[1] && d_we && ram_din !== d_wdata)) begin
        n_bad++; $display("FAIL rnd_wren[%0d]: got we=%b din=%h want we=%b din=%h", c, ram_wren, ram_din, eg[1] & d_we, d_wdata);
      end
      if (eg != 2'b00) begin
        n_cmp++;
        if (ram_addr !== (eg[0] ? i_addr : d_addr)) begin
          n_bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, ram_addr, eg[0] ? i_addr : d_addr);
        end
      end
      n_cmp++;
      if ({d_valid, i_valid} !== ev) begin
        n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, {d_valid, i_valid}, ev);
      end
      if (ev != 2'b00 && !m_exp_wr) begin
        n_cmp++;
        if ((ev[0] ? i_rdata : d_rdata) !== m_exp_data) begin
          n_bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, ev[0] ? i_rdata : d_rdata, m_exp_data);
        end
      end
      n_cmp++;
      if ((i_valid & d_valid) || (i_gnt & d_gnt) || (ram_wren & !(d_gnt & d_we))) begin
        n_bad++; $display("FAIL rnd_invariant[%0d]: got iv=%b dv=%b ig=%b dg=%b we=%b", c, i_valid, d_valid, i_gnt, d_gnt, ram_wren);
      end
      if (i_gnt) begin
        n_cmp++;
        if (iw > 1) begin n_bad++; $display("FAIL rnd_starve_i[%0d]: waited %0d want <=1", c, iw); end
        ip = 1'b0;
      end else if (ip) iw++;
      if (d_gnt) begin
        n_cmp++;
        if (dw > 1) begin n_bad++; $display("FAIL rnd_starve_d[%0d]: waited %0d want <=1", c, dw); end
        dp = 1'b0;
      end else if (dp) dw++;
      model_commit(eg);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    clear = 1'b0; ram_init = 1'b1;
    drive(0, 8'h00, 0, 0, 8'h00, 32'h0);
    for (int k = 0; k < 256; k++) m_mem[k] = init_val(8'(k));
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    ram_init = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_back_to_back();
    test_reset_midaccess();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
